// File: rtl/ctr_turn_scheduler.sv
// rtl/ctr_turn_scheduler.sv - two-player turn arbiter sharing one ctr counter
// Grants the counter per turn, loads the player's value, scores win/lose events.
module ctr_turn_scheduler #(
    parameter int COUNTER_SIZE = 4,
    parameter int TURN_CYCLES  = 16,
    parameter int WIN_SCORE    = 3,
    parameter int SCORE_W      = 4
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic [1:0]              req,
    input  logic [1:0]              p0_control,
    input  logic [1:0]              p1_control,
    input  logic [COUNTER_SIZE-1:0] p0_init_value,
    input  logic [COUNTER_SIZE-1:0] p1_init_value,
    input  logic                    ctr_winner,
    input  logic                    ctr_loser,
    output logic [1:0]              control,
    output logic [COUNTER_SIZE-1:0] initial_value,
    output logic                    INIT,
    output logic [1:0]              gnt,
    output logic [SCORE_W-1:0]      p0_score,
    output logic [SCORE_W-1:0]      p1_score,
    output logic                    game_over,
    output logic                    champion
);
    localparam int TCW = $clog2(TURN_CYCLES + 1);

    typedef enum logic [2:0] {IDLE, LOAD, RUN, SWITCH, DONE} state_t;

    state_t                  state_q, state_d;
    logic                    g_q, g_d;
    logic                    last_q, last_d;
    logic [TCW-1:0]          turn_q, turn_d;
    logic [1:0]              control_q, control_d;
    logic [COUNTER_SIZE-1:0] initial_value_q, initial_value_d;
    logic                    init_q, init_d;
    logic [1:0]              gnt_q, gnt_d;
    logic [SCORE_W-1:0]      p0_score_q, p0_score_d;
    logic [SCORE_W-1:0]      p1_score_q, p1_score_d;
    logic                    game_over_q, game_over_d;
    logic                    champion_q, champion_d;
    logic                    sel_g;
    logic                    leave;

    function automatic logic [SCORE_W-1:0] sat_inc(input logic [SCORE_W-1:0] v);
        return (&v) ? v : v + SCORE_W'(1);
    endfunction

    always_comb begin
        state_d         = state_q;
        g_d             = g_q;
        last_d          = last_q;
        turn_d          = turn_q;
        control_d       = control_q;
        initial_value_d = initial_value_q;
        init_d          = init_q;
        gnt_d           = gnt_q;
        p0_score_d      = p0_score_q;
        p1_score_d      = p1_score_q;
        game_over_d     = game_over_q;
        champion_d      = champion_q;
        leave           = 1'b0;
        // Tie goes to whoever did not play last
        sel_g           = (req == 2'b11) ? ~last_q : req[1];

        case (state_q)
            IDLE: begin
                if (req != 2'b00) begin
                    g_d             = sel_g;
                    control_d       = sel_g ? p1_control : p0_control;
                    initial_value_d = sel_g ? p1_init_value : p0_init_value;
                    init_d          = 1'b1;
                    gnt_d           = sel_g ? 2'b10 : 2'b01;
                    state_d         = LOAD;
                end
            end
            LOAD: begin
                init_d  = 1'b0;
                turn_d  = '0;
                state_d = RUN;
            end
            RUN: begin
                if (ctr_winner) begin
                    leave = 1'b1;
                    if (g_q) p1_score_d = sat_inc(p1_score_q);
                    else     p0_score_d = sat_inc(p0_score_q);
                end else if (ctr_loser) begin
                    leave = 1'b1;
                    if (g_q) p0_score_d = sat_inc(p0_score_q);
                    else     p1_score_d = sat_inc(p1_score_q);
                end else if (turn_q == TCW'(TURN_CYCLES - 1)) begin
                    leave = 1'b1;
                end
                if (leave) begin
                    gnt_d     = 2'b00;
                    control_d = 2'b00;
                    state_d   = SWITCH;
                end else begin
                    turn_d = turn_q + TCW'(1);
                end
            end
            SWITCH: begin
                last_d = g_q;
                turn_d = '0;
                if (p0_score_q == SCORE_W'(WIN_SCORE)) begin
                    game_over_d = 1'b1;
                    champion_d  = 1'b0;
                    state_d     = DONE;
                end else if (p1_score_q == SCORE_W'(WIN_SCORE)) begin
                    game_over_d = 1'b1;
                    champion_d  = 1'b1;
                    state_d     = DONE;
                end else begin
                    state_d = IDLE;
                end
            end
            DONE: begin
                state_d = DONE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q         <= IDLE;
            g_q             <= 1'b0;
            last_q          <= 1'b1;
            turn_q          <= '0;
            control_q       <= 2'b00;
            initial_value_q <= '0;
            init_q          <= 1'b0;
            gnt_q           <= 2'b00;
            p0_score_q      <= '0;
            p1_score_q      <= '0;
            game_over_q     <= 1'b0;
            champion_q      <= 1'b0;
        end else begin
            state_q         <= state_d;
            g_q             <= g_d;
            last_q          <= last_d;
            turn_q          <= turn_d;
            control_q       <= control_d;
            initial_value_q <= initial_value_d;
            init_q          <= init_d;
            gnt_q           <= gnt_d;
            p0_score_q      <= p0_score_d;
            p1_score_q      <= p1_score_d;
            game_over_q     <= game_over_d;
            champion_q      <= champion_d;
        end
    end

    assign control       = control_q;
    assign initial_value = initial_value_q;
    assign INIT          = init_q;
    assign gnt           = gnt_q;
    assign p0_score      = p0_score_q;
    assign p1_score      = p1_score_q;
    assign game_over     = game_over_q;
    assign champion      = champion_q;
endmodule

// File: tb/tb_ctr_turn_scheduler.sv
// tb/tb_ctr_turn_scheduler.sv - scoreboard bench for ctr_turn_scheduler
module tb_ctr_turn_scheduler;
    logic       clock = 1'b0;
    logic       reset;
    logic [1:0] req;
    logic [1:0] p0_control, p1_control;
    logic [3:0] p0_init_value, p1_init_value;
    logic       ctr_winner, ctr_loser;
    logic [1:0] control;
    logic [3:0] initial_value;
    logic       INIT;
    logic [1:0] gnt;
    logic [3:0] p0_score, p1_score;
    logic       game_over, champion;

    ctr_turn_scheduler #(
        .COUNTER_SIZE(4), .TURN_CYCLES(16), .WIN_SCORE(3), .SCORE_W(4)
    ) dut (
        .clock(clock), .reset(reset), .req(req),
        .p0_control(p0_control), .p1_control(p1_control),
        .p0_init_value(p0_init_value), .p1_init_value(p1_init_value),
        .ctr_winner(ctr_winner), .ctr_loser(ctr_loser),
        .control(control), .initial_value(initial_value), .INIT(INIT),
        .gnt(gnt), .p0_score(p0_score), .p1_score(p1_score),
        .game_over(game_over), .champion(champion)
    );

    always #5 clock = ~clock;

    typedef struct { logic [1:0] gnt; logic [1:0] ctl; logic [3:0] iv; } load_exp_t;
    typedef struct { logic [3:0] p0; logic [3:0] p1; int run; } sw_exp_t;

    load_exp_t load_q[$];
    sw_exp_t   sw_q[$];
    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Monitor: a load is presented when INIT is high, a turn ends when gnt falls
    int         run_cnt = 0;
    logic [1:0] prev_gnt = 2'b00;
    load_exp_t  le;
    sw_exp_t    se;
    always @(negedge clock) begin
        if (reset) begin
            prev_gnt = 2'b00;
            run_cnt  = 0;
        end else begin
            if (INIT) begin
                if (load_q.size() == 0) begin
                    check("unexpected_init", {31'd0, INIT}, 32'd0);
                end else begin
                    le = load_q.pop_front();
                    check("load_gnt", {30'd0, gnt}, {30'd0, le.gnt});
                    check("load_control", {30'd0, control}, {30'd0, le.ctl});
                    check("load_initial_value", {28'd0, initial_value}, {28'd0, le.iv});
                end
                run_cnt = 0;
            end else if (gnt != 2'b00) begin
                run_cnt++;
            end
            if (prev_gnt != 2'b00 && gnt == 2'b00) begin
                if (sw_q.size() == 0) begin
                    check("unexpected_switch", {30'd0, prev_gnt}, 32'd0);
                end else begin
                    se = sw_q.pop_front();
                    check("switch_p0_score", {28'd0, p0_score}, {28'd0, se.p0});
                    check("switch_p1_score", {28'd0, p1_score}, {28'd0, se.p1});
                    check("switch_run_cycles", run_cnt, se.run);
                    check("switch_control", {30'd0, control}, 32'd0);
                end
            end
            prev_gnt = gnt;
        end
    end

    task automatic check_reset_values(input string tag);
        check({tag, "_control"}, {30'd0, control}, 32'd0);
        check({tag, "_initial_value"}, {28'd0, initial_value}, 32'd0);
        check({tag, "_INIT"}, {31'd0, INIT}, 32'd0);
        check({tag, "_gnt"}, {30'd0, gnt}, 32'd0);
        check({tag, "_p0_score"}, {28'd0, p0_score}, 32'd0);
        check({tag, "_p1_score"}, {28'd0, p1_score}, 32'd0);
        check({tag, "_game_over"}, {31'd0, game_over}, 32'd0);
        check({tag, "_champion"}, {31'd0, champion}, 32'd0);
    endtask

    // win_at/lose_at: RUN cycle number of the event pulse; 0 means during LOAD, -1 none
    task automatic do_turn(input logic [1:0] r, input logic hold,
                           input logic [1:0] eg, input logic [1:0] ectl, input logic [3:0] eiv,
                           input int win_at, input int lose_at,
                           input logic [3:0] ep0, input logic [3:0] ep1, input int erun);
        logic seen;
        logic done;
        load_q.push_back('{eg, ectl, eiv});
        sw_q.push_back('{ep0, ep1, erun});
        req  = r;
        seen = 1'b0;
        for (int i = 0; i < 6 && !seen; i++) begin
            @(negedge clock);
            seen = INIT;
        end
        check("init_seen", {31'd0, seen}, 32'd1);
        if (!hold) req = 2'b00;
        ctr_winner = (win_at == 0);
        ctr_loser  = (lose_at == 0);
        done = 1'b0;
        for (int c = 1; c <= 40 && !done; c++) begin
            @(negedge clock);
            ctr_winner = (c == win_at);
            ctr_loser  = (c == lose_at);
            if (gnt == 2'b00) begin
                done       = 1'b1;
                ctr_winner = 1'b0;
                ctr_loser  = 1'b0;
            end
        end
        check("switch_seen", {31'd0, done}, 32'd1);
        @(negedge clock);
    endtask

    initial begin
        logic seen;
        reset = 1'b1; req = 2'b00;
        p0_control = 2'b01; p0_init_value = 4'd9;
        p1_control = 2'b10; p1_init_value = 4'd5;
        ctr_winner = 1'b0; ctr_loser = 1'b0;
        @(negedge clock); @(negedge clock);
        check_reset_values("reset");
        reset = 1'b0;

        // single request, full-length turn with no events
        do_turn(2'b01, 1'b0, 2'b01, 2'b01, 4'd9, -1, -1, 4'd0, 4'd0, 16);
        // both requesting continuously: grants alternate
        do_turn(2'b11, 1'b1, 2'b10, 2'b10, 4'd5, -1, -1, 4'd0, 4'd0, 16);
        do_turn(2'b11, 1'b1, 2'b01, 2'b01, 4'd9, -1, -1, 4'd0, 4'd0, 16);
        do_turn(2'b11, 1'b0, 2'b10, 2'b10, 4'd5, -1, -1, 4'd0, 4'd0, 16);
        // player 1 wins on RUN cycle 5
        do_turn(2'b10, 1'b0, 2'b10, 2'b10, 4'd5, 5, -1, 4'd0, 4'd1, 5);
        // winner and loser together: only the granted player scores
        p0_control = 2'b11; p0_init_value = 4'd3;
        do_turn(2'b01, 1'b0, 2'b01, 2'b11, 4'd3, 3, 3, 4'd1, 4'd1, 3);
        // winner during LOAD is ignored, loser credits the other player
        do_turn(2'b01, 1'b0, 2'b01, 2'b11, 4'd3, 0, 2, 4'd1, 4'd2, 2);
        // event in the timeout cycle is scored
        do_turn(2'b01, 1'b0, 2'b01, 2'b11, 4'd3, 16, -1, 4'd2, 4'd2, 16);
        // third win ends the game
        do_turn(2'b01, 1'b0, 2'b01, 2'b11, 4'd3, 1, -1, 4'd3, 4'd2, 1);
        check("done_game_over", {31'd0, game_over}, 32'd1);
        check("done_champion", {31'd0, champion}, 32'd0);

        req = 2'b11; ctr_winner = 1'b1; ctr_loser = 1'b1;
        repeat (5) @(negedge clock);
        check("done_gnt", {30'd0, gnt}, 32'd0);
        check("done_p0_hold", {28'd0, p0_score}, 32'd3);
        check("done_p1_hold", {28'd0, p1_score}, 32'd2);
        check("done_game_over_hold", {31'd0, game_over}, 32'd1);
        req = 2'b00; ctr_winner = 1'b0; ctr_loser = 1'b0;

        reset = 1'b1;
        @(negedge clock);
        check_reset_values("reset_from_done");
        reset = 1'b0;

        // build scores 2/1, then reset in the middle of a turn
        p0_control = 2'b01; p0_init_value = 4'd9;
        do_turn(2'b01, 1'b0, 2'b01, 2'b01, 4'd9, 2, -1, 4'd1, 4'd0, 2);
        do_turn(2'b01, 1'b0, 2'b01, 2'b01, 4'd9, 4, -1, 4'd2, 4'd0, 4);
        do_turn(2'b10, 1'b0, 2'b10, 2'b10, 4'd5, 1, -1, 4'd2, 4'd1, 1);
        load_q.push_back('{2'b01, 2'b01, 4'd9});
        req  = 2'b01;
        seen = 1'b0;
        for (int i = 0; i < 6 && !seen; i++) begin
            @(negedge clock);
            seen = INIT;
        end
        check("midrun_init_seen", {31'd0, seen}, 32'd1);
        req = 2'b00;
        repeat (3) @(negedge clock);
        check("midrun_gnt_before_reset", {30'd0, gnt}, 32'd1);
        reset = 1'b1;
        @(negedge clock);
        check_reset_values("reset_mid_run");
        reset = 1'b0;
        // pointer reset: player 0 wins the first tie
        do_turn(2'b11, 1'b0, 2'b01, 2'b01, 4'd9, -1, -1, 4'd0, 4'd0, 16);

        check("load_queue_drained", load_q.size(), 32'd0);
        check("switch_queue_drained", sw_q.size(), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/ctr_turn_scheduler.md
Name: ctr_turn_scheduler

Overview:
- Turn-based arbiter and sequencer that shares one `ctr` counter instance between two players.
- Grants the counter to one player at a time and loads that player's initial value through INIT.
- Drives the player's mode on control for a bounded turn, scores WINNER/LOSER events reported by the counter, and declares game over at a target score.
- Sits directly above `ctr` and owns its control, initial_value and INIT inputs.

Parameters:
- COUNTER_SIZE, 4, width of counter value / initial_value.
- TURN_CYCLES, 16, maximum RUN cycles per turn (>=1).
- WIN_SCORE, 3, score that ends the game (1..15).
- SCORE_W, 4, width of score registers.

Ports:
- clock  in  1  system clock, rising edge.
- reset  in  1  synchronous, active-high reset.
- req  in  2  per-player turn request; bit0 = player 0, bit1 = player 1.
- p0_control  in  2  player 0 counter mode.
- p1_control  in  2  player 1 counter mode.
- p0_init_value  in  COUNTER_SIZE  player 0 load value.
- p1_init_value  in  COUNTER_SIZE  player 1 load value.
- ctr_winner  in  1  one-cycle pulse from the counter: winner condition.
- ctr_loser  in  1  one-cycle pulse from the counter: loser condition.
- control  out  2  mode driven to the counter.
- initial_value  out  COUNTER_SIZE  load value driven to the counter.
- INIT  out  1  counter load strobe.
- gnt  out  2  one-hot grant; zero when no turn is active.
- p0_score  out  SCORE_W  player 0 score.
- p1_score  out  SCORE_W  player 1 score.
- game_over  out  1  high in DONE.
- champion  out  1  id of the player that reached WIN_SCORE; valid when game_over=1.

Behaviour:
- All outputs are registered. Reset (synchronous, active-high) forces:
  - state=IDLE, control=2'b00, initial_value=0, INIT=0, gnt=0, scores=0, game_over=0, champion=0;
  - turn counter=0; round-robin pointer last=1, so player 0 wins the first tie.
- Reset asserted in any state, including mid-RUN or DONE, returns to these values on the next edge.
- FSM states: IDLE, LOAD, RUN, SWITCH, DONE.
- IDLE:
  - If req!=0 at a rising edge, select the granted player g and go to LOAD.
  - Selection: if only one bit of req is set, g is that player; if both are set, g = ~last.
  - At selection, latch g's control and init_value into internal registers. Later changes on the p*_ inputs are ignored until the next turn.
- LOAD (exactly 1 cycle):
  - INIT=1, initial_value=latched value, control=latched mode, gnt=onehot(g).
  - Next state: RUN.
- RUN:
  - INIT=0; control and gnt hold; turn counter increments each cycle from 0.
  - ctr_winner=1: score[g]+=1, go to SWITCH.
  - Else ctr_loser=1: score[~g]+=1, go to SWITCH.
  - Else turn counter == TURN_CYCLES-1 (timeout): no score change, go to SWITCH.
  - Winner and loser in the same cycle: winner takes priority, and only one score changes.
  - An event in the timeout cycle is scored.
  - Deasserting req during RUN has no effect.
  - ctr_winner and ctr_loser are ignored outside RUN. This includes the LOAD cycle.
- SWITCH (1 cycle):
  - gnt=0, control=2'b00, INIT=0; last=g; turn counter cleared.
  - If either score == WIN_SCORE: go to DONE, set champion to that player and set game_over=1.
  - Otherwise go to IDLE.
- DONE:
  - Terminal; outputs as in SWITCH with game_over=1; req is ignored until reset.
- Scores saturate at 2^SCORE_W-1; this is never reached when WIN_SCORE fits in SCORE_W.
- Latency:
  - Idle-to-INIT: req sampled at edge k gives INIT=1 during cycle k+1.
  - Turn length: at most 1 (LOAD) + TURN_CYCLES (RUN) + 1 (SWITCH) cycles.

Test Plan:
- Reset, then req=01, p0_control=01, p0_init_value=9 → INIT=1 for exactly one cycle with initial_value=9, control=01, gnt=01. After 16 RUN cycles with no events: SWITCH, gnt=0, scores 0/0.
- req=11 held continuously, no events → grants alternate gnt=01,10,01,10. Each turn lasts 18 cycles, and INIT pulses once per turn.
- Player 1 granted, ctr_winner pulse on RUN cycle 5 → p1_score=1 next cycle, immediate SWITCH, turn ends early.
- Player 0 granted, ctr_winner and ctr_loser asserted in the same cycle → p0_score+1 only, p1_score unchanged.
- Player 0 scores 3 winner events across turns → DONE, game_over=1, champion=0. Further req and events are ignored; assert reset → all outputs return to their reset values.
- Assert reset mid-RUN with scores 2/1 → next cycle state is IDLE, scores 0/0, gnt=0. With req=11, the first grant goes to player 0.
